// File: rtl/button_conditioner.sv
// Synchronises, debounces and auto-repeats raw push buttons for the game logic.
// Each button yields a debounced level, a one-cycle press/repeat strobe and a sticky request.
module button_conditioner #(
    parameter int unsigned       N_BTN           = 4,
    parameter int unsigned       DEBOUNCE_CYCLES = 250000,
    parameter int unsigned       REPEAT_DELAY    = 7500000,
    parameter int unsigned       REPEAT_PERIOD   = 2500000,
    parameter logic [N_BTN-1:0]  REPEAT_MASK     = N_BTN'(4'b1110),
    parameter int unsigned       CNT_W           = 23
) (
    input  logic             CLK25M,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] ack,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_req
);

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HELD_DELAY,
        HELD_REPEAT,
        DEB_RELEASE
    } state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] level_nxt;
    logic [N_BTN-1:0] press_nxt;
    logic [N_BTN-1:0] req_nxt;

    // Two-flop synchroniser; the FSMs only ever see sync2
    always_ff @(posedge CLK25M or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar gi = 0; gi < int'(N_BTN); gi++) begin : g_btn
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_d;
        logic             strobe_d;
        logic             s;

        assign s = sync2[gi];

        always_ff @(posedge CLK25M or posedge Reset) begin
            if (Reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Next-state, counter and per-button output decode
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            level_d  = btn_level[gi];
            strobe_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = DEB_PRESS;
                        cnt_d   = '0;
                    end
                end
                DEB_PRESS: begin
                    if (!s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d  = HELD_DELAY;
                        cnt_d    = '0;
                        level_d  = 1'b1;
                        strobe_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HELD_DELAY: begin
                    if (!s) begin
                        state_d = DEB_RELEASE;
                        cnt_d   = '0;
                    end else if (cnt_q == DELAY_LAST) begin
                        // Non-repeating buttons park here with the count saturated
                        if (REPEAT_MASK[gi]) begin
                            state_d  = HELD_REPEAT;
                            cnt_d    = '0;
                            strobe_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HELD_REPEAT: begin
                    if (!s) begin
                        state_d = DEB_RELEASE;
                        cnt_d   = '0;
                    end else if (cnt_q == PERIOD_LAST) begin
                        cnt_d    = '0;
                        strobe_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                DEB_RELEASE: begin
                    if (s) begin
                        state_d = HELD_DELAY;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        level_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        assign level_nxt[gi] = level_d;
        assign press_nxt[gi] = strobe_d;
    end

    // A strobe sets the request even if ack arrives in the same cycle
    assign req_nxt = press_nxt | (btn_req & ~ack);

    always_ff @(posedge CLK25M or posedge Reset) begin
        if (Reset) begin
            btn_level <= '0;
            btn_press <= '0;
            btn_req   <= '0;
        end else begin
            btn_level <= level_nxt;
            btn_press <= press_nxt;
            btn_req   <= req_nxt;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed vector bench for button_conditioner with shortened debounce/repeat timing.
module tb_button_conditioner;

    logic       CLK25M;
    logic       Reset;
    logic [3:0] btn_raw;
    logic [3:0] ack;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_req;

    int unsigned checks;
    int unsigned errors;

    typedef struct {
        int unsigned edge_n;
        logic [3:0]  raw;
        logic [3:0]  ack;
        logic [3:0]  level;
        logic [3:0]  press;
        logic [3:0]  req;
    } vec_t;

    vec_t vecs[$];

    button_conditioner #(
        .N_BTN          (4),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .REPEAT_MASK    (4'b1110),
        .CNT_W          (23)
    ) dut (
        .CLK25M   (CLK25M),
        .Reset    (Reset),
        .btn_raw  (btn_raw),
        .ack      (ack),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_req  (btn_req)
    );

    initial CLK25M = 1'b0;
    always #5 CLK25M = ~CLK25M;

    task automatic tick();
        @(posedge CLK25M);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                           input logic [3:0] rq);
        chk({tag, " level"}, btn_level, lvl);
        chk({tag, " press"}, btn_press, prs);
        chk({tag, " req"}, btn_req, rq);
    endtask

    task automatic do_reset();
        btn_raw = '0;
        ack     = '0;
        Reset   = 1'b1;
        tick();
        Reset   = 1'b0;
    endtask

    function automatic void add(input int unsigned e, input logic [3:0] raw, input logic [3:0] a,
                                input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rq);
        vec_t v;
        v.edge_n = e;
        v.raw    = raw;
        v.ack    = a;
        v.level  = lvl;
        v.press  = prs;
        v.req    = rq;
        vecs.push_back(v);
    endfunction

    initial begin
        int unsigned cur;
        checks  = 0;
        errors  = 0;
        Reset   = 1'b1;
        btn_raw = '0;
        ack     = '0;
        cur     = 0;

        // Rows: inputs applied just before edge_n, outputs expected just after it.
        // Clean hold on L with ack handshake
        add( 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add( 5, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add( 6, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010);
        add( 7, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
        add(10, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        add(15, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        add(16, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010);
        add(17, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        add(18, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        add(19, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010);
        add(22, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010);
        add(25, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010);
        add(28, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010);
        add(31, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010);
        add(34, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010);
        add(37, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010);
        add(38, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
        add(40, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010);
        add(41, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
        add(45, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
        add(46, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
        add(47, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        // Bounce on D shorter than the debounce window
        add( 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add( 2, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add( 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add( 4, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add( 6, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(10, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // T held: single strobe, no repeats
        add( 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add( 5, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add( 6, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
        add( 7, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        add(16, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        add(17, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        add(19, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        add(30, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        add(39, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        add(40, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        add(45, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        add(46, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(47, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        // L and R together, R released early
        add( 0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add( 6, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b1010);
        add( 7, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'b1010);
        add(12, 4'b0010, 4'b0000, 4'b1010, 4'b0000, 4'b1010);
        add(16, 4'b0010, 4'b0000, 4'b1010, 4'b0010, 4'b1010);
        add(17, 4'b0010, 4'b0000, 4'b1010, 4'b0000, 4'b1010);
        add(18, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1010);
        add(19, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b1010);
        add(22, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b1010);

        #2;
        chk_all("reset_state", 4'b0000, 4'b0000, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].edge_n == 0) begin
                do_reset();
                cur = 0;
            end
            while (cur < vecs[i].edge_n) begin
                ack = '0;
                tick();
                cur++;
            end
            btn_raw = vecs[i].raw;
            ack     = vecs[i].ack;
            tick();
            cur++;
            ack = '0;
            chk_all($sformatf("vec%0d_e%0d", i, vecs[i].edge_n),
                    vecs[i].level, vecs[i].press, vecs[i].req);
        end

        // Async reset in the middle of auto-repeat, button still held
        do_reset();
        btn_raw = 4'b0010;
        for (int e = 0; e < 20; e++) tick();
        chk_all("pre_reset_e19", 4'b0010, 4'b0010, 4'b0010);
        #2;
        Reset = 1'b1;
        #1;
        chk_all("async_reset", 4'b0000, 4'b0000, 4'b0000);
        for (int e = 20; e < 24; e++) tick();
        chk_all("held_reset_e23", 4'b0000, 4'b0000, 4'b0000);
        Reset = 1'b0;
        for (int e = 24; e < 30; e++) tick();
        chk_all("post_reset_e29", 4'b0000, 4'b0000, 4'b0000);
        tick();
        chk_all("post_reset_e30", 4'b0010, 4'b0010, 4'b0010);
        tick();
        chk_all("post_reset_e31", 4'b0010, 4'b0000, 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
